// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, issues instruction-memory requests
// over a req/ready handshake, arbitrates redirects against hazard stalls,
// and raises the IF/ID and ID/EX flushes on an accepted redirect.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             hz_stall,
  input  logic             ex_valid,
  input  logic [2:0]       ex_npc_op,
  input  logic             ex_branch_taken,
  input  logic [31:0]      npc_in,
  output logic [2:0]       npc_op,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  output logic [31:0]      pc,
  output logic             if_valid,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [CNT_W-1:0] redir_cnt
);

  localparam logic [2:0]  OP_PLUS4  = 3'b000;
  localparam logic [2:0]  OP_BRANCH = 3'b001;
  localparam logic [2:0]  OP_JUMP   = 3'b010;
  localparam logic [2:0]  OP_JALR   = 3'b100;
  localparam logic [31:0] ALIGN_MSK = 32'hFFFF_FFFE;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,  // no request outstanding
    BUSY  = 2'd1,  // request outstanding, response wanted
    PEND  = 2'd2   // request outstanding, response is wrong-path
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;
  logic             redir;
  logic             req_int;
  logic             valid_int;

  // Redirect decode and its combinational side effects (mux op, flushes, counter)
  always_comb begin
    redir = rstn & ex_valid &
            ((ex_npc_op == OP_JUMP) | (ex_npc_op == OP_JALR) |
             ((ex_npc_op == OP_BRANCH) & ex_branch_taken));
    npc_op      = redir ? ex_npc_op : OP_PLUS4;
    flush_ifid  = redir;
    flush_idex  = redir;
    redir_cnt_d = redir_cnt_q;
    if (redir && (redir_cnt_q != '1)) begin
      redir_cnt_d = redir_cnt_q + CNT_W'(1);
    end
  end

  // Next-state, PC update and handshake outputs
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    req_int   = 1'b0;
    valid_int = 1'b0;
    case (state_q)
      ISSUE: begin
        if (redir) begin
          pc_d = npc_in & ALIGN_MSK;
        end else if (!hz_stall) begin
          req_int = 1'b1;
          if (imem_ready) begin
            valid_int = 1'b1;
            pc_d      = npc_in & ALIGN_MSK;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        req_int = 1'b1;
        if (redir) begin
          if (imem_ready) begin
            pc_d    = npc_in & ALIGN_MSK;
            state_d = ISSUE;
          end else begin
            pend_pc_d = npc_in;
            state_d   = PEND;
          end
        end else if (imem_ready) begin
          // A stall at completion drops the response and leaves the PC,
          // so the same address is fetched again from ISSUE.
          state_d = ISSUE;
          if (!hz_stall) begin
            valid_int = 1'b1;
            pc_d      = npc_in & ALIGN_MSK;
          end
        end
      end
      PEND: begin
        req_int = 1'b1;
        if (redir) begin
          pend_pc_d = npc_in;
        end
        if (imem_ready) begin
          pc_d    = (redir ? npc_in : pend_pc_q) & ALIGN_MSK;
          state_d = ISSUE;
        end
      end
      default: begin
        state_d = ISSUE;
      end
    endcase
  end

  // Outputs forced quiet while reset is held
  always_comb begin
    imem_req  = rstn & req_int;
    if_valid  = rstn & valid_int;
    imem_addr = pc_q;
    pc        = pc_q;
    redir_cnt = redir_cnt_q;
  end

  // State, PC and counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ISSUE;
      pc_q        <= RESET_PC;
      pend_pc_q   <= '0;
      redir_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_pc_q   <= pend_pc_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// transaction-level model (outstanding / wrong-path flags, PC, counter).
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rstn;
  logic        hz_stall, ex_valid, ex_branch_taken, imem_ready;
  logic [2:0]  ex_npc_op;
  logic [31:0] npc_in;
  logic [2:0]  npc_op;
  logic        imem_req, if_valid, flush_ifid, flush_idex;
  logic [31:0] imem_addr, pc;
  logic [15:0] redir_cnt;

  int errors = 0;
  int checks = 0;

  // model state
  logic [31:0] m_pc, m_pend;
  logic [15:0] m_cnt;
  bit          m_out, m_wrong;

  pc_fetch_ctrl #(.RESET_PC(RST_PC), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn), .hz_stall(hz_stall), .ex_valid(ex_valid),
    .ex_npc_op(ex_npc_op), .ex_branch_taken(ex_branch_taken), .npc_in(npc_in),
    .npc_op(npc_op), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .pc(pc), .if_valid(if_valid),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .redir_cnt(redir_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: model outputs vs DUT each cycle, model advance at posedge
  initial begin
    bit          have_next;
    bit          redir, req, done, ev;
    logic [31:0] n_pc, n_pend;
    logic [15:0] n_cnt;
    bit          n_out, n_wrong;
    forever begin
      @(negedge clk);
      #1;
      have_next = 0;
      if (!rstn) begin
        m_pc = RST_PC; m_pend = '0; m_cnt = '0; m_out = 0; m_wrong = 0;
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_flush", {30'b0, flush_ifid, flush_idex}, 32'd0);
        chk("rst_npc_op", {29'b0, npc_op}, 32'd0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_cnt", {16'b0, redir_cnt}, 32'd0);
      end else begin
        redir = ex_valid && ((ex_npc_op == 3'b010) || (ex_npc_op == 3'b100) ||
                             ((ex_npc_op == 3'b001) && ex_branch_taken));
        req   = m_out || (!redir && !hz_stall);
        done  = req && imem_ready;
        ev    = done && !m_wrong && !redir && !hz_stall;
        chk("m_req", {31'b0, imem_req}, {31'b0, req});
        chk("m_valid", {31'b0, if_valid}, {31'b0, ev});
        chk("m_flush_ifid", {31'b0, flush_ifid}, {31'b0, redir});
        chk("m_flush_idex", {31'b0, flush_idex}, {31'b0, redir});
        chk("m_npc_op", {29'b0, npc_op}, redir ? {29'b0, ex_npc_op} : 32'd0);
        chk("m_pc", pc, m_pc);
        chk("m_addr", imem_addr, m_pc);
        chk("m_cnt", {16'b0, redir_cnt}, {16'b0, m_cnt});
        n_pc = m_pc; n_pend = m_pend;
        if (redir) begin
          if (m_out && !imem_ready) n_pend = npc_in;
          else                      n_pc   = npc_in & ~32'd1;
        end else if (done) begin
          if (m_wrong)        n_pc = m_pend & ~32'd1;
          else if (!hz_stall) n_pc = npc_in & ~32'd1;
        end
        n_out   = req && !imem_ready;
        n_wrong = n_out && (m_wrong || redir);
        n_cnt   = (redir && m_cnt != 16'hFFFF) ? m_cnt + 16'd1 : m_cnt;
        have_next = 1;
      end
      @(posedge clk);
      if (have_next && rstn) begin
        m_pc = n_pc; m_pend = n_pend; m_cnt = n_cnt; m_out = n_out; m_wrong = n_wrong;
      end
    end
  end

  task automatic drv(input logic st, input logic ev, input logic [2:0] op,
                     input logic tk, input logic [31:0] npc, input logic rdy);
    @(negedge clk);
    hz_stall = st; ex_valid = ev; ex_npc_op = op; ex_branch_taken = tk;
    npc_in = npc; imem_ready = rdy;
  endtask

  initial begin
    logic [2:0] ops [8];
    ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b011, 3'b101, 3'b110, 3'b111};
    rstn = 1'b0; hz_stall = 0; ex_valid = 0; ex_npc_op = 0; ex_branch_taken = 0;
    npc_in = 0; imem_ready = 0;
    repeat (3) @(negedge clk);
    #2;
    chk("reset_pc", pc, 32'h100);
    chk("reset_req", {31'b0, imem_req}, 32'd0);

    // zero-wait sequential fetch
    drv(0, 0, 3'b000, 0, 32'h104, 1); rstn = 1'b1;
    #2 chk("seq_addr0", imem_addr, 32'h100); chk("seq_valid0", {31'b0, if_valid}, 32'd1);
    drv(0, 0, 3'b000, 0, 32'h108, 1);
    #2 chk("seq_addr1", imem_addr, 32'h104); chk("seq_valid1", {31'b0, if_valid}, 32'd1);

    // taken branch at 0x108
    drv(0, 1, 3'b001, 1, 32'h200, 1);
    #2 chk("br_addr", imem_addr, 32'h108); chk("br_npc_op", {29'b0, npc_op}, 32'd1);
    chk("br_flush", {30'b0, flush_ifid, flush_idex}, 32'd3);
    chk("br_valid", {31'b0, if_valid}, 32'd0); chk("br_req", {31'b0, imem_req}, 32'd0);
    drv(0, 0, 3'b000, 0, 32'h204, 1);
    #2 chk("br_target", imem_addr, 32'h200); chk("br_cnt", {16'b0, redir_cnt}, 32'd1);
    chk("br_flush_end", {30'b0, flush_ifid, flush_idex}, 32'd0);

    // JALR redirect while waiting
    drv(0, 0, 3'b000, 0, 32'h208, 0);
    #2 chk("wt_req", {31'b0, imem_req}, 32'd1);
    drv(0, 1, 3'b100, 0, 32'h301, 0);
    #2 chk("wt_flush", {30'b0, flush_ifid, flush_idex}, 32'd3);
    chk("wt_npc_op", {29'b0, npc_op}, 32'd4);
    drv(0, 0, 3'b000, 0, 32'h208, 0);
    #2 chk("wt_addr_frozen", imem_addr, 32'h204);
    drv(0, 0, 3'b000, 0, 32'h208, 1);
    #2 chk("wt_discard", {31'b0, if_valid}, 32'd0);
    drv(0, 0, 3'b000, 0, 32'h304, 1);
    #2 chk("wt_target", imem_addr, 32'h300); chk("wt_target_valid", {31'b0, if_valid}, 32'd1);

    // stall in ISSUE, then stall at BUSY completion
    drv(1, 0, 3'b000, 0, 32'h308, 1);
    #2 chk("st_req0", {31'b0, imem_req}, 32'd0);
    drv(1, 0, 3'b000, 0, 32'h308, 1);
    #2 chk("st_req1", {31'b0, imem_req}, 32'd0); chk("st_pc", pc, 32'h304);
    drv(0, 0, 3'b000, 0, 32'h308, 0);
    drv(1, 0, 3'b000, 0, 32'h308, 1);
    #2 chk("st_busy_valid", {31'b0, if_valid}, 32'd0);
    drv(0, 0, 3'b000, 0, 32'h308, 1);
    #2 chk("st_refetch", imem_addr, 32'h304); chk("st_refetch_v", {31'b0, if_valid}, 32'd1);

    // redirect beats stall
    drv(1, 1, 3'b010, 0, 32'h400, 1);
    #2 chk("rs_flush", {30'b0, flush_ifid, flush_idex}, 32'd3);
    drv(0, 0, 3'b000, 0, 32'h404, 1);
    #2 chk("rs_target", imem_addr, 32'h400); chk("rs_cnt", {16'b0, redir_cnt}, 32'd3);

    // counter saturation
    for (int i = 0; i < 65540; i++) drv(0, 1, 3'b010, 0, 32'h500, 1);
    drv(0, 0, 3'b000, 0, 32'h504, 1);
    #2 chk("sat_cnt", {16'b0, redir_cnt}, 32'hFFFF);

    // reset asserted mid-BUSY
    drv(0, 0, 3'b000, 0, 32'h508, 0);
    drv(0, 0, 3'b000, 0, 32'h508, 0);
    #2 chk("mb_req_before", {31'b0, imem_req}, 32'd1);
    #1 rstn = 1'b0;
    #1 chk("mb_req_drop", {31'b0, imem_req}, 32'd0);
    chk("mb_pc", pc, RST_PC); chk("mb_cnt", {16'b0, redir_cnt}, 32'd0);
    drv(0, 0, 3'b000, 0, 32'h0, 0);
    drv(0, 0, 3'b000, 0, 32'h0, 0);
    drv(0, 0, 3'b000, 0, 32'h104, 1); rstn = 1'b1;
    #2 chk("mb_restart", imem_addr, RST_PC);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic ev;
      ev = ($urandom_range(0, 9) < 3);
      drv(($urandom_range(0, 9) < 2), ev, ops[$urandom_range(0, 7)], 1'($urandom),
          ev ? $urandom : m_pc + 32'd4, ($urandom_range(0, 9) < 6));
    end
    @(negedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
